// File: rtl/bus_endpoint_sync.sv
// Synchronous parallel-bus endpoint: decodes a RANGE-word window at BASE_ADDR and
// answers req with a one-cycle ack after WAIT_STATES extra cycles. Writes are byte-enabled.
module bus_endpoint_sync #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int BASE_ADDR   = 0,
    parameter int RANGE       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    r_wn,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    ack,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    busy
);

    localparam int IDXW   = $clog2(RANGE);
    localparam int NBYTES = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (DATA_WIDTH % 8 != 0) begin : gBadDataWidth
        $fatal(1, "bus_endpoint_sync: DATA_WIDTH must be a multiple of 8");
    end
    if (RANGE < 2) begin : gBadRange
        $fatal(1, "bus_endpoint_sync: RANGE must be at least 2");
    end
    if (longint'(BASE_ADDR) + longint'(RANGE) > (longint'(1) << ADDR_WIDTH)) begin : gBadWindow
        $fatal(1, "bus_endpoint_sync: window exceeds the address space");
    end
    if (WAIT_STATES > 255 || WAIT_STATES < 0) begin : gBadWait
        $fatal(1, "bus_endpoint_sync: WAIT_STATES must be 0..255");
    end

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [RANGE];
    logic                  doAccess;

    logic [ADDR_WIDTH-1:0] addrOff;
    logic [IDXW-1:0]       idx;
    logic                  hit;

    // An address below BASE_ADDR wraps to at least 2**ADDR_WIDTH-BASE_ADDR, which is never
    // below RANGE, so one unsigned compare covers both window edges.
    assign addrOff = addr - ADDR_WIDTH'(BASE_ADDR);
    assign hit     = {1'b0, addrOff} < (ADDR_WIDTH+1)'(RANGE);
    assign idx     = addrOff[IDXW-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        busy_d   = busy_q;
        rdata_d  = '0;
        doAccess = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && hit) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'(WAIT_STATES);
                    busy_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    doAccess = 1'b1;
                    state_d  = ST_DONE;
                    ack_d    = 1'b1;
                    busy_d   = 1'b0;
                    if (r_wn) begin
                        rdata_d = mem_q[idx];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            for (int r = 0; r < RANGE; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            if (doAccess && !r_wn) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (be[i]) begin
                        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign ack   = ack_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_endpoint_sync.sv
// Two endpoints share one bus (OR-combined rdata); a per-address memory model predicts
// read data and the ack latency of whichever window an address falls into.
module tb_bus_endpoint_sync;

    logic        clk;
    logic        rst;
    logic        req;
    logic        r_wn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack0, ack1, busy0, busy1;
    logic [31:0] rdata0, rdata1;

    int checks;
    int passCount;
    logic [31:0] model [256];

    bus_endpoint_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(16), .RANGE(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .r_wn(r_wn), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack0), .rdata(rdata0), .busy(busy0)
    );

    bus_endpoint_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(40), .RANGE(6), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .req(req), .r_wn(r_wn), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack1), .rdata(rdata1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    function automatic int windowWait(input logic [7:0] a);
        if (a >= 8'd16 && a <= 8'd31) return 0;
        if (a >= 8'd40 && a <= 8'd45) return 3;
        return -1;
    endfunction

    // One full bus transaction from the master's side; expectations come from the model.
    task automatic applyStimulus(input logic [7:0] a, input logic rw, input logic [31:0] wd, input logic [3:0] b);
        int          ws;
        int          ackCycle;
        int          busyCnt;
        logic        leak;
        logic [31:0] seen;
        logic [31:0] expData;
        ws       = windowWait(a);
        ackCycle = 0;
        busyCnt  = 0;
        leak     = 1'b0;
        seen     = '0;
        expData  = rw ? model[a] : 32'd0;
        addr  = a;
        r_wn  = rw;
        wdata = wd;
        be    = b;
        req   = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack0 | ack1) begin
                ackCycle = k;
                seen     = rdata0 | rdata1;
                break;
            end
            if ((rdata0 | rdata1) != 32'd0) leak = 1'b1;
            if (busy0 | busy1) busyCnt++;
        end
        req = 1'b0;
        checkOutput($sformatf("rdataIdle@%0d", a), 32'(leak), 32'd0);
        if (ws < 0) begin
            checkOutput($sformatf("missAck@%0d", a), 32'(ackCycle), 32'd0);
            checkOutput($sformatf("missBusy@%0d", a), 32'(busyCnt), 32'd0);
        end else begin
            checkOutput($sformatf("latency@%0d", a), 32'(ackCycle), 32'(ws + 2));
            checkOutput($sformatf("rdata@%0d", a), seen, expData);
            checkOutput($sformatf("busyCycles@%0d", a), 32'(busyCnt), 32'(ws + 1));
            if (!rw) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) model[a][8*i +: 8] = wd[8*i +: 8];
                end
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("doneAck@%0d", a), 32'(ack0 | ack1), 32'd0);
            checkOutput($sformatf("doneRdata@%0d", a), rdata0 | rdata1, 32'd0);
        end
    endtask

    initial begin
        logic sawAck;
        checks    = 0;
        passCount = 0;
        for (int i = 0; i < 256; i++) model[i] = '0;
        rst   = 1'b1;
        req   = 1'b0;
        r_wn  = 1'b1;
        addr  = '0;
        wdata = '0;
        be    = '0;
        #3;
        checkOutput("resetAck", 32'({ack0, ack1}), 32'd0);
        checkOutput("resetBusy", 32'({busy0, busy1}), 32'd0);
        checkOutput("resetRdata", rdata0 | rdata1, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 16; a <= 31; a++) applyStimulus(8'(a), 1'b1, 32'd0, 4'h0);

        applyStimulus(8'd20, 1'b0, 32'hAABBCCDD, 4'hF);
        applyStimulus(8'd20, 1'b0, 32'h11223344, 4'b0101);
        applyStimulus(8'd20, 1'b1, 32'd0, 4'h0);
        checkOutput("byteMerge", model[20], 32'hAA22CC44);

        applyStimulus(8'd41, 1'b0, 32'hCAFE0001, 4'hF);
        applyStimulus(8'd41, 1'b1, 32'd0, 4'h0);

        applyStimulus(8'd21, 1'b0, 32'h12345678, 4'h0);
        applyStimulus(8'd21, 1'b1, 32'd0, 4'h0);

        applyStimulus(8'd15, 1'b1, 32'd0, 4'h0);
        applyStimulus(8'd32, 1'b1, 32'd0, 4'h0);
        applyStimulus(8'd39, 1'b0, 32'hFFFFFFFF, 4'hF);
        applyStimulus(8'd46, 1'b0, 32'hFFFFFFFF, 4'hF);
        applyStimulus(8'd16, 1'b0, 32'h00000016, 4'hF);
        applyStimulus(8'd31, 1'b0, 32'h00000031, 4'hF);
        applyStimulus(8'd40, 1'b0, 32'h00000040, 4'hF);
        applyStimulus(8'd45, 1'b0, 32'h00000045, 4'hF);
        applyStimulus(8'd16, 1'b1, 32'd0, 4'h0);
        applyStimulus(8'd45, 1'b1, 32'd0, 4'h0);

        // Abort: drop req two edges into a write on the wait-state endpoint.
        addr  = 8'd42;
        r_wn  = 1'b0;
        wdata = 32'h0000005A;
        be    = 4'hF;
        req   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        req    = 1'b0;
        sawAck = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            sawAck = sawAck | ack0 | ack1;
        end
        checkOutput("abortAck", 32'(sawAck), 32'd0);
        checkOutput("abortBusy", 32'(busy1), 32'd0);
        applyStimulus(8'd42, 1'b1, 32'd0, 4'h0);

        repeat (40) begin
            applyStimulus(8'($urandom_range(10, 50)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset in the middle of a waiting write wipes everything, including the write.
        addr  = 8'd43;
        r_wn  = 1'b0;
        wdata = 32'hDEADBEEF;
        be    = 4'hF;
        req   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midResetAck", 32'({ack0, ack1}), 32'd0);
        checkOutput("midResetBusy", 32'({busy0, busy1}), 32'd0);
        checkOutput("midResetRdata", rdata0 | rdata1, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = '0;
        applyStimulus(8'd43, 1'b1, 32'd0, 4'h0);
        applyStimulus(8'd20, 1'b1, 32'd0, 4'h0);
        applyStimulus(8'd16, 1'b1, 32'd0, 4'h0);

        $display("%0d/%0d checks passed", passCount, checks);
        $finish;
    end

endmodule

// File: doc/bus_endpoint_sync.md
Name: bus_endpoint_sync

Overview:
- Clocked, parametrised successor to the combinational-strobe native parallel bus endpoint.
- Decodes a window of RANGE words at BASE_ADDR, holds local register storage, and responds with a req/ack handshake after a programmable number of wait states.
- Supports byte-enabled writes and abort of a pending access.
- Several instances share one bus. rdata is driven zero when not acknowledging, so the bus master can OR-combine all endpoints.

Parameters:
- ADDR_WIDTH, 8, bus address width in bits
- DATA_WIDTH, 8, bus data width in bits; must be a multiple of 8
- BASE_ADDR, 0, first bus address decoded by this instance
- RANGE, 16, number of words in the window; must be >= 2
- WAIT_STATES, 0, extra cycles inserted before ack; 0..255

Ports:
- clk  input  1  bus clock; all state changes on its rising edge
- rst  input  1  asynchronous active-high reset
- req  input  1  master request; held high until ack is seen
- r_wn  input  1  1 = read, 0 = write; stable while req is high
- addr  input  ADDR_WIDTH  bus word address; stable while req is high
- wdata  input  DATA_WIDTH  write data; stable while req is high
- be  input  DATA_WIDTH/8  byte enables for writes; be[i] selects wdata[8i+7:8i]
- ack  output  1  one-cycle completion pulse, this instance only
- rdata  output  DATA_WIDTH  read data, valid only while ack=1 for a read; 0 at all other times
- busy  output  1  high while a transaction is accepted and not yet completed or aborted

Behaviour:
- Elaboration-time checks; each violation is a fatal error:
  - DATA_WIDTH % 8 != 0
  - RANGE < 2
  - BASE_ADDR+RANGE > 2**ADDR_WIDTH
  - WAIT_STATES > 255
- Decode (combinational):
  - hit = (addr >= BASE_ADDR) && (addr <= BASE_ADDR+RANGE-1).
  - Local index = addr-BASE_ADDR, truncated to $clog2(RANGE) bits.
- Storage: RANGE x DATA_WIDTH registers.
- Reset, asynchronous on rst high:
  - state=IDLE, ack=0, rdata=0, busy=0, wait counter=0, all storage words=0.
  - Reset during WAIT discards the access; no write occurs.
- State machine, states IDLE, WAIT, DONE:
  - IDLE: if req && hit, go to WAIT, load counter=WAIT_STATES, busy=1. Otherwise stay; a non-hit request is ignored (no ack, rdata stays 0).
  - WAIT, req low: abort. Go to IDLE, busy=0, no storage update, no ack.
  - WAIT, req high and counter != 0: counter decrements.
  - WAIT, req high and counter == 0: perform the access and go to DONE with ack=1, busy=0.
    - Write: storage[idx] byte i <= wdata byte i for each be[i]=1; other bytes unchanged. rdata=0.
    - Read: rdata <= storage[idx].
  - DONE: ack=0, rdata=0; go to IDLE unconditionally. req is ignored in this cycle.
- Latency:
  - Acceptance edge E. ack is high in the cycle following edge E+1+WAIT_STATES.
  - With WAIT_STATES=0, ack follows the second edge after req is first sampled high.
- Master contract: deassert req in the cycle ack is seen. Because DONE ignores req, a still-high req is sampled again in IDLE one edge later and accepted as a new transaction. Back-to-back accesses cost WAIT_STATES+3 cycles each.
- Write with be all zero: completes with ack; storage unchanged.
- Signals on non-hit addresses:
  - Changing addr/r_wn/wdata/be while in WAIT is a protocol violation; the value sampled at the completing edge is used.
  - The decode is not re-checked after acceptance.
- Window edges: BASE_ADDR-1 and BASE_ADDR+RANGE are misses; BASE_ADDR and BASE_ADDR+RANGE-1 are hits.
- Index wrap: when RANGE is not a power of two, index values >= RANGE are unreachable.

Test Plan:
- Reset, then read every in-range address with BASE_ADDR=16, RANGE=16, WAIT_STATES=0 -> each ack follows the second edge after req; rdata=0; busy high exactly 1 cycle per access.
- DATA_WIDTH=32: write 0xAABBCCDD with be=4'hF to addr 20, then write 0x11223344 with be=4'b0101 to addr 20, then read addr 20 -> rdata=0xAA22CC44.
- WAIT_STATES=3: write then read addr 17 -> ack occurs exactly 4 cycles after the acceptance edge; rdata outside the ack cycle is 0.
- Requests to addr 15 and addr 32 (misses) with BASE_ADDR=16, RANGE=16 -> no ack for 20 cycles; rdata=0; busy=0; addr 16 and addr 31 are acked.
- WAIT_STATES=5: write 0x5A to addr 18, drop req after 2 cycles, then read addr 18 -> no ack on the aborted write; read returns the prior value 0.
- Assert rst while in WAIT of a write to addr 19, release, then read addr 19 -> ack, rdata, busy and storage all 0; read returns 0.
